// File: rtl/dft_seq_ctrl.sv
// Frame sequencer for the serial DFT datapath: load pass, n/k term streams, MAC drain, bin handshake.
// Optional macro HALF_SPECTRUM_EN limits the computed bins to 0..N/2.
module dft_seq_ctrl #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned MAC_LAT = 3
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ce,
   input  logic              start,
   input  logic [ADDR_W-1:0] sample_num,
   output logic              cache_we,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [ADDR_W-1:0] n_idx,
   output logic [ADDR_W-1:0] k_idx,
   output logic              term_valid,
   output logic              acc_clear,
   output logic              bin_valid,
   output logic [ADDR_W-1:0] bin_idx,
   input  logic              bin_ready,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_OUT} state_t;

   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [3:0]        LAT_LAST = 4'(MAC_LAT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [3:0]        lat_q, lat_d;
   logic              cfg_err_d;
   logic              done_d;
   logic [ADDR_W-1:0] k_last;

`ifdef HALF_SPECTRUM_EN
   assign k_last = len_q >> 1;
`else
   assign k_last = len_q - ONE;
`endif

   // One counter serves as the cache address during LOAD and as n during COMPUTE.
   assign cache_addr = cnt_q;
   assign n_idx      = cnt_q;
   assign k_idx      = k_q;
   assign bin_idx    = k_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      len_d     = len_q;
      lat_d     = lat_q;
      cfg_err_d = cfg_err;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (sample_num > ONE) begin
                  len_d     = sample_num;
                  cfg_err_d = 1'b0;
                  cnt_d     = '0;
                  k_d       = '0;
                  state_d   = S_LOAD;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (cnt_q == len_q - ONE) begin
               cnt_d   = '0;
               k_d     = '0;
               state_d = S_COMPUTE;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_COMPUTE: begin
            if (cnt_q == len_q - ONE) begin
               lat_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_DRAIN: begin
            if (lat_q == LAT_LAST) state_d = S_OUT;
            else                   lat_d   = lat_q + 4'd1;
         end
         S_OUT: begin
            if (bin_ready) begin
               cnt_d = '0;
               if (k_q == k_last) begin
                  k_d     = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  k_d     = k_q + ONE;
                  state_d = S_COMPUTE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are registered from the next-state decode so they line up with the counters.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         k_q        <= '0;
         len_q      <= '0;
         lat_q      <= '0;
         cache_we   <= 1'b0;
         term_valid <= 1'b0;
         acc_clear  <= 1'b0;
         bin_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
      end else if (ce) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         len_q      <= len_d;
         lat_q      <= lat_d;
         cache_we   <= (state_d == S_LOAD);
         term_valid <= (state_d == S_COMPUTE);
         acc_clear  <= (state_d == S_COMPUTE) && (cnt_d == '0);
         bin_valid  <= (state_d == S_OUT);
         busy       <= (state_d != S_IDLE);
         done       <= done_d;
         cfg_err    <= cfg_err_d;
      end
   end

endmodule

// File: doc/dft_seq_ctrl.md
Name: dft_seq_ctrl

Overview:
Parametrised frame sequencer for the serial DFT datapath. It latches the frame length when a frame is started. It then runs a cache-load pass and generates the n/k index streams for the multiply-accumulate (MAC) datapath. It tracks MAC pipeline latency and presents each finished bin through a valid/ready handshake.

Parameters:
ADDR_W, 12, width of sample/bin indices and of sample_num; maximum N is 2**ADDR_W-1.
MAC_LAT, 3, cycles from the last term_valid of a bin to the MAC result being stable; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
ce  in  1  clock enable; when low, all state, counters and outputs hold
start  in  1  begin-frame request; samples are already in the input buffer
sample_num  in  ADDR_W  frame length N; sampled only on an accepted start
cache_we  out  1  write strobe to the sample cache during the load pass
cache_addr  out  ADDR_W  cache write address
n_idx  out  ADDR_W  sample index of the term currently issued
k_idx  out  ADDR_W  bin index of the term currently issued
term_valid  out  1  one MAC term issued this cycle
acc_clear  out  1  accumulator restart; high together with the term where n_idx==0
bin_valid  out  1  MAC result for bin_idx is ready
bin_idx  out  ADDR_W  bin number qualifying bin_valid
bin_ready  in  1  downstream accepts the bin
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a frame completes
cfg_err  out  1  sticky flag for an illegal sample_num

Behaviour:
- All outputs are registered. The FSM and counters advance only on clock edges where ce=1.
- Reset values: IDLE state; all counters 0; cache_we, term_valid, acc_clear, bin_valid, busy, done and cfg_err all 0.
- States: IDLE, LOAD, COMPUTE, DRAIN, OUT.
- IDLE:
  - start=1 with sample_num>=2: latch N = sample_num, go to LOAD.
  - start=1 with sample_num<2: set cfg_err and stay in IDLE.
  - cfg_err clears only on an accepted start with a legal N, or on reset.
- LOAD:
  - cache_we=1 for exactly N cycles; cache_addr counts 0..N-1.
  - After the N-1 beat, go to COMPUTE with k=0, n=0.
- COMPUTE:
  - term_valid=1 for exactly N cycles; n_idx counts 0..N-1 with k_idx constant.
  - acc_clear=1 only on the n_idx==0 beat.
  - After the n==N-1 beat, go to DRAIN.
- DRAIN: hold for MAC_LAT cycles; term_valid=0; go to OUT.
- OUT:
  - bin_valid=1 and bin_idx=k, both held stable until bin_ready=1.
  - On handshake, if k==K_LAST: done pulses for 1 cycle and the FSM returns to IDLE.
  - Otherwise k increments, n resets to 0 and the FSM returns to COMPUTE.
  - With full-spectrum operation, K_LAST = N-1.
- Cycles per bin with bin_ready tied high: N + MAC_LAT + 1.
- Frame length: busy stays high for N + K·(N+MAC_LAT+1) enabled cycles, where K is the number of bins.
- A start received while busy=1 is ignored; it is neither queued nor checked for cfg_err.
- Negating nrst at any point, including mid-LOAD or mid-COMPUTE, immediately forces reset values. The partial frame is abandoned and no done is produced.
- Holding ce low in OUT keeps bin_valid high. A bin_ready seen while ce=0 is not a handshake.
- Counters are ADDR_W wide. The largest legal N still fits, so no index ever wraps.

Optional Feature:
HALF_SPECTRUM_EN:
- Defined: the block uses real-input symmetry and computes only bins 0..floor(N/2), so K_LAST = N>>1 and K = (N>>1)+1.
- Undefined: all N bins are computed, K_LAST = N-1.
- LOAD and the per-bin sequence are identical in both builds.

Test Plan:
- N=4, MAC_LAT=3, bin_ready=1, full build, start pulse → 4 cache_we beats with addresses 0..3. Then 4 bins of 8 cycles each; term_valid is high 16 times in total. bin_idx sequence 0,1,2,3; done pulse; busy high for 36 cycles.
- Same stimulus with HALF_SPECTRUM_EN, N=5 → bins 0,1,2 only; busy high for 5+3·9=32 cycles.
- N=4 with bin_ready held low for 5 cycles at bin 1 → bin_valid and bin_idx=1 stay stable for 6 cycles and no term_valid is issued. Bin 2 then starts on the cycle after the handshake.
- sample_num=1 with start → cfg_err=1, busy stays 0. A following start with N=3 clears cfg_err and runs a normal frame.
- nrst asserted on the third COMPUTE beat of bin 2 (N=8) → all outputs are 0 asynchronously and no done is produced. A new start then runs cleanly from k=0.
- ce toggled 1,0,1,0 throughout an N=4 frame → the sequence is identical to the first test, stretched to 72 cycles. A start pulse injected mid-frame is ignored.
